// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction over imem req/ack,
// and holds the decoded fields stable until the control unit commits the instruction.
//
// state  | meaning
// IDLE   | just out of reset, start fetching on the next edge
// FETCH  | imem_req high at pc, waiting for imem_ack
// DECODE | instr held for decode/execute, waiting for ex_done
// HALT   | PCWre=0 seen, stopped until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  input  logic [31:0] ext_imm,
  input  logic        ex_done,
  input  logic        PCWre,
  input  logic        PCSrc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic        instr_valid_next;
  logic        halted_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign imm16     = instr[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_valid <= instr_valid_next;
      halted      <= halted_next;
      // request is registered so it rises together with entry into FETCH
      imem_req    <= (state_next == FETCH);
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = instr;
    instr_valid_next = instr_valid;
    halted_next      = halted;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_valid_next = 1'b1;
          state_next       = DECODE;
        end
      end
      DECODE: begin
        if (ex_done) begin
          instr_valid_next = 1'b0;
          if (!PCWre) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            pc_next    = PCSrc ? (pc_plus4 + (ext_imm << 2)) : pc_plus4;
            state_next = FETCH;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives imem and control-unit signals by hand
// and compares against hand-computed PCs and fields.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] ext_imm;
  logic        ex_done;
  logic        PCWre;
  logic        PCSrc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .ext_imm(ext_imm), .ex_done(ex_done), .PCWre(PCWre), .PCSrc(PCSrc),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_commit(input logic wre, input logic src, input logic [31:0] imm);
    PCWre   = wre;
    PCSrc   = src;
    ext_imm = imm;
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; ext_imm = 32'h0;
    ex_done = 1'b0; PCWre = 1'b1; PCSrc = 1'b0;
    tick(); tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
    rst_n = 1'b1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req: got %b want 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_addr: got %h want 0", imem_addr); end
    do_fetch(32'h0401_0005);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", instr_valid); end
    n_checks++; if (instr !== 32'h0401_0005) begin n_fail++; $display("FAIL zw_instr: got %h want 04010005", instr); end
    n_checks++; if (opcode !== 6'b000001) begin n_fail++; $display("FAIL zw_opcode: got %b want 000001", opcode); end
    n_checks++; if (rs !== 5'd0) begin n_fail++; $display("FAIL zw_rs: got %0d want 0", rs); end
    n_checks++; if (rt !== 5'd1) begin n_fail++; $display("FAIL zw_rt: got %0d want 1", rt); end
    n_checks++; if (rd !== 5'd0) begin n_fail++; $display("FAIL zw_rd: got %0d want 0", rd); end
    n_checks++; if (imm16 !== 16'h0005) begin n_fail++; $display("FAIL zw_imm16: got %h want 0005", imm16); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_req_decode: got %b want 0", imem_req); end
    do_commit(1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL zw_seq_addr: got %h want 4", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid_clear: got %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req_refetch: got %b want 1", imem_req); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_req[%0d]: got %b want 1", i, imem_req); end
      n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h want 4", i, imem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid[%0d]: got %b want 0", i, instr_valid); end
      imem_rdata = 32'hBAD0_0000 + i;
      if (i < 3) tick();
    end
    do_fetch(32'h1234_5678);
    n_checks++; if (instr !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_instr: got %h want 12345678", instr); end
    do_commit(1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL ws_seq_addr: got %h want 8", imem_addr); end
  endtask

  task automatic test_branch();
    do_fetch(32'h1000_FFFE);
    // ack while in DECODE must not overwrite instr
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (instr !== 32'h1000_FFFE) begin n_fail++; $display("FAIL br_ack_ignored: got %h want 1000fffe", instr); end
    do_commit(1'b1, 1'b1, 32'hFFFF_FFFE);
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL br_back_addr: got %h want 4", imem_addr); end
    do_fetch(32'h0);
    do_commit(1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_seq_addr: got %h want 8", imem_addr); end
    do_fetch(32'h1000_0003);
    do_commit(1'b1, 1'b1, 32'h0000_0003);
    n_checks++; if (imem_addr !== 32'd24) begin n_fail++; $display("FAIL br_fwd_addr: got %h want 18", imem_addr); end
  endtask

  task automatic test_halt();
    do_fetch(32'hFC00_0000);
    n_checks++; if (opcode !== 6'b111111) begin n_fail++; $display("FAIL ht_opcode: got %b want 111111", opcode); end
    do_commit(1'b0, 1'b0, 32'h0);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ht_halted: got %b want 1", halted); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ht_valid: got %b want 0", instr_valid); end
    for (int i = 0; i < 20; i++) begin
      ex_done = i[0]; PCWre = 1'b1; PCSrc = i[1]; ext_imm = 32'h10;
      imem_ack = ~i[0]; imem_rdata = 32'h5555_0000 + i;
      tick();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ht_req[%0d]: got %b want 0", i, imem_req); end
      n_checks++; if (pc !== 32'd24) begin n_fail++; $display("FAIL ht_pc[%0d]: got %h want 18", i, pc); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ht_stay[%0d]: got %b want 1", i, halted); end
    end
    ex_done = 1'b0; imem_ack = 1'b0;
    n_checks++; if (instr !== 32'hFC00_0000) begin n_fail++; $display("FAIL ht_instr: got %h want fc000000", instr); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL ht_rst_pc: got %h want 0", pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ht_rst_halted: got %b want 0", halted); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ht_resume_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ht_resume_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    ex_done = 1'b1; PCWre = 1'b1; PCSrc = 1'b1; ext_imm = 32'h5;
    tick();
    ex_done = 1'b0;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL stray_ex_addr: got %h want 0", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stray_ex_req: got %b want 1", imem_req); end
    do_fetch(32'h0);
    do_commit(1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ar_pre_addr: got %h want 4", imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", imem_req); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL ar_pc: got %h want 0", pc); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_resume_req: got %b want 1", imem_req); end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0);
    do_commit(1'b1, 1'b1, 32'hFFFF_FFFE);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_top_addr: got %h want fffffffc", imem_addr); end
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wr_pc_plus4: got %h want 0", pc_plus4); end
    do_fetch(32'h0);
    do_commit(1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_addr: got %h want 0", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
